// File: rtl/if_id_queue.sv
// IF/ID queue: DEPTH-entry circular buffer between fetch and decode with
// valid/ready handshakes, branch/jump flush, head-entry field decode and stall statistics.
module if_id_queue #(
   parameter int DEPTH  = 2,
   parameter int PC_W   = 32,
   parameter int SIDE_W = 1
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [PC_W-1:0]            in_pc,
   input  logic [31:0]                in_instr,
   input  logic [SIDE_W-1:0]          in_side,
   input  logic                       flush_branch,
   input  logic                       flush_jump,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [PC_W-1:0]            out_pc,
   output logic [31:0]                out_instr,
   output logic [SIDE_W-1:0]          out_side,
   output logic [5:0]                 op_code,
   output logic [4:0]                 rs,
   output logic [4:0]                 rt,
   output logic [4:0]                 rd,
   output logic [15:0]                imm,
   output logic [25:0]                jump_offset,
   output logic [$clog2(DEPTH+1)-1:0] occupancy,
   output logic [15:0]                stall_cycles
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int OCC_W = $clog2(DEPTH+1);
   localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);

   logic [PC_W-1:0]   r_pc_mem    [DEPTH];
   logic [31:0]       r_instr_mem [DEPTH];
   logic [SIDE_W-1:0] r_side_mem  [DEPTH];

   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [OCC_W-1:0] r_occ;
   logic [15:0]      r_stall;

   logic w_flush;
   logic w_in_ready;
   logic w_out_valid;
   logic w_push;
   logic w_pop;

   logic [PC_W-1:0]   w_head_pc;
   logic [31:0]       w_head_instr;
   logic [SIDE_W-1:0] w_head_side;

   assign w_flush     = flush_branch | flush_jump;
   // in_ready comes only from registered occupancy, so out_ready never reaches it
   assign w_in_ready  = (r_occ != OCC_FULL);
   assign w_out_valid = (r_occ != '0) & ~w_flush;
   assign w_push      = in_valid & w_in_ready & ~w_flush;
   assign w_pop       = w_out_valid & out_ready;

   // Head is zeroed whenever it is not valid, giving decode a NOP bubble
   assign w_head_pc    = w_out_valid ? r_pc_mem[r_rd_ptr]    : '0;
   assign w_head_instr = w_out_valid ? r_instr_mem[r_rd_ptr] : '0;
   assign w_head_side  = w_out_valid ? r_side_mem[r_rd_ptr]  : '0;

   always_ff @(posedge clk) begin
      if (w_push & ~reset) begin
         r_pc_mem[r_wr_ptr]    <= in_pc;
         r_instr_mem[r_wr_ptr] <= in_instr;
         r_side_mem[r_wr_ptr]  <= in_side;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_occ    <= '0;
         r_stall  <= '0;
      end else begin
         if (w_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
         end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
               2'b10:   r_occ <= r_occ + 1'b1;
               2'b01:   r_occ <= r_occ - 1'b1;
               default: r_occ <= r_occ;
            endcase
         end
         // Statistics survive flushes; only reset clears them
         if (in_valid & ~w_in_ready & ~w_flush & (r_stall != 16'hFFFF))
            r_stall <= r_stall + 16'd1;
      end
   end

   assign in_ready     = w_in_ready;
   assign out_valid    = w_out_valid;
   assign out_pc       = w_head_pc;
   assign out_instr    = w_head_instr;
   assign out_side     = w_head_side;
   assign op_code      = w_head_instr[31:26];
   assign rs           = w_head_instr[25:21];
   assign rt           = w_head_instr[20:16];
   assign rd           = w_head_instr[15:11];
   assign imm          = w_head_instr[15:0];
   assign jump_offset  = w_head_instr[25:0];
   assign occupancy    = r_occ;
   assign stall_cycles = r_stall;

endmodule
